rv_sink: RTL and testbench

Slave (receiving) end of the 8-bit ready/valid byte channel. Accepts a byte on every clock edge where `master_valid` and `slave_ready` are both high, and buffers it in a small first-word-fall-through FIFO. It then presents the bytes in order to a local consumer through a pop interface. Sits at the consumer side of any ready/valid link, opposite the master that drives `data`/`master_valid`.

---
 rtl/rv_pkg.sv | 9 +
 rtl/rv_sync_fifo.sv | 65 ++++++
 rtl/rv_sink.sv | 77 +++++++
 tb/tb_rv_sink.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and types for the 8-bit ready/valid byte channel.
package rv_pkg;

  localparam int unsigned RV_DW         = 8;
  localparam int unsigned RV_SINK_DEPTH = 4;

  typedef logic [RV_DW-1:0] rv_byte_t;

endpackage

// File: rtl/rv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and synchronous flush.
module rv_sync_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = RV_SINK_DEPTH,
  parameter int unsigned DW    = RV_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Flush wins over both ports; a byte offered in a flush cycle is dropped.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv_sink.sv
// Receiving end of the ready/valid byte channel, buffered into a FWFT FIFO.
// Optional transfer counter output enabled by defining RV_SINK_XFER_CNT_EN.
module rv_sink
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = RV_SINK_DEPTH,
  parameter int unsigned DW    = RV_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          data,
  input  logic                   master_valid,
  output logic                   slave_ready,
  input  logic                   flush,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow
`ifdef RV_SINK_XFER_CNT_EN
  ,
  output logic [15:0]            xfer_count
`endif
);

  logic push;
  logic underflow_q;

  // Ready depends only on registered pointer state, never on master_valid.
  assign slave_ready = !full;
  assign push        = master_valid && slave_ready;
  assign underflow   = underflow_q;

  rv_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (data),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (flush) begin
      underflow_q <= 1'b0;
    end else if (rd_en && empty) begin
      underflow_q <= 1'b1;
    end
  end

`ifdef RV_SINK_XFER_CNT_EN
  logic [15:0] xfer_count_q;

  assign xfer_count = xfer_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
    end else if (flush) begin
      xfer_count_q <= '0;
    end else if (push) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_sink.sv
// Self-checking bench for rv_sink: queue-based model plus directed literal checks.
module tb_rv_sink;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  rv_byte_t   data;
  logic       master_valid;
  logic       slave_ready;
  logic       flush;
  logic       rd_en;
  rv_byte_t   rd_data;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic       underflow;
`ifdef RV_SINK_XFER_CNT_EN
  logic [15:0] xfer_count;
`endif

  int nchecks = 0;
  int nerrors = 0;

  rv_sink #(
    .DEPTH (DEPTH),
    .DW    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .flush        (flush),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .underflow    (underflow)
`ifdef RV_SINK_XFER_CNT_EN
    ,
    .xfer_count   (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of accepted bytes plus sticky flag and transfer count.
  byte unsigned q[$];
  bit           m_under = 1'b0;
  int unsigned  m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) begin
      q.delete();
      m_under = 1'b0;
      m_cnt   = 0;
    end else if (flush) begin
      q.delete();
      m_under = 1'b0;
      m_cnt   = 0;
    end else begin
      n = q.size();
      if (rd_en && n == 0) m_under = 1'b1;
      if (rd_en && n > 0) void'(q.pop_front());
      if (master_valid && n < DEPTH) begin
        q.push_back(data);
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_level", 32'(level), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_ready", 32'(slave_ready), 32'(q.size() < DEPTH));
      chk("m_underflow", 32'(underflow), 32'(m_under));
      if (q.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(q[0]));
`ifdef RV_SINK_XFER_CNT_EN
      chk("m_xfer_count", 32'(xfer_count), m_cnt);
`endif
    end
  end

  task automatic cyc(input logic mv, input logic [7:0] d, input logic rd, input logic fl);
    master_valid = mv;
    data         = d;
    rd_en        = rd;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte unsigned drain [4];
    drain = '{8'h22, 8'h33, 8'h44, 8'h55};

    rst_n = 1'b0; data = '0; master_valid = 1'b0; flush = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_ready", 32'(slave_ready), 32'd1);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);

    // Fill to full, then offer a fifth byte that must be held off.
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("first_push_rd_data", 32'(rd_data), 32'h11);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    chk("fill3_level", 32'(level), 32'd3);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    chk("fill4_full", 32'(full), 32'd1);
    chk("fill4_ready", 32'(slave_ready), 32'd0);
    chk("fill4_level", 32'(level), 32'd4);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("held_off_level", 32'(level), 32'd4);
    chk("held_off_head", 32'(rd_data), 32'h11);

    // Pop from full while 0x55 is offered: pop only, ready rises next cycle.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pop_full_head", 32'(rd_data), 32'h22);
    chk("pop_full_level", 32'(level), 32'd3);
    chk("pop_full_ready", 32'(slave_ready), 32'd1);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("accept55_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(rd_data), 32'(drain[i]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained_empty", 32'(empty), 32'd1);

    // Concurrent push/pop at level 2 across pointer wrap.
    cyc(1'b1, 8'hA0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", 32'(rd_data), 32'(8'hA0 + i));
      cyc(1'b1, 8'(8'hA2 + i), 1'b1, 1'b0);
      chk("stream_level", 32'(level), 32'd2);
    end
    chk("stream_tail_head", 32'(rd_data), 32'hAA);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_empty", 32'(empty), 32'd1);

    // Underflow is sticky until flush; flush drops the concurrent offer.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_set", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("underflow_sticky", 32'(underflow), 32'd1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("pre_flush_level", 32'(level), 32'd1);
    cyc(1'b1, 8'h88, 1'b0, 1'b1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_underflow", 32'(underflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);

    // Push while empty with rd_en: byte kept, underflow flagged.
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_push_level", 32'(level), 32'd1);
    chk("empty_push_data", 32'(rd_data), 32'h5A);
    chk("empty_push_underflow", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef RV_SINK_XFER_CNT_EN
    chk("count_after_flush", 32'(xfer_count), 32'd0);
    for (int i = 0; i < 70000; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    chk("count_wrap", 32'(xfer_count), 32'd4464);
`endif

    // Asynchronous reset mid-stream.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("pre_reset_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(slave_ready), 32'd1);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full", 32'(full), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_underflow", 32'(underflow), 32'd0);
`ifdef RV_SINK_XFER_CNT_EN
    chk("async_rst_count", 32'(xfer_count), 32'd0);
`endif
    master_valid = 1'b0;
    rd_en        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_reset_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
